// File: rtl/controlador_de_interrupcao.sv
// Interrupt controller: sticky pending causes, IDLE/REQ/SERVICE handshake with the control unit,
// user/kernel mode flag and an optional preemption timer enabled by the INTR_TIMER_EN macro.
module controlador_de_interrupcao #(
    parameter int unsigned QUANTUM = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        userMode,
    input  logic        kernelMode,
    input  logic        inta,
    input  logic        clearIntr,
    input  logic        ioReq,
    input  logic        diskDone,
    input  logic [31:0] pc,
    output logic        intr,
    output logic [31:0] intCode,
    output logic [31:0] intPc,
    output logic        isUser
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    localparam logic [31:0] CODE_NONE    = 32'd0;
    localparam logic [31:0] CODE_QUANTUM = 32'd1;
    localparam logic [31:0] CODE_INPUT   = 32'd2;
    localparam logic [31:0] CODE_DISK    = 32'd3;

    state_t      state;
    state_t      state_next;
    logic        intr_next;
    logic [31:0] code_next;
    logic [31:0] pc_next;
    logic        user_next;

    logic        pend_quantum;
    logic        pend_input;
    logic        pend_disk;
    logic        any_pending;

    logic        ack;
    logic [31:0] ack_code;
    logic        clr_input;
    logic        clr_disk;

    // Acknowledge only exists in REQ; the winning cause is the one cleared.
    always_comb begin
        ack         = (state == REQ) && inta;
        any_pending = pend_quantum || pend_input || pend_disk;
        ack_code    = CODE_NONE;
        if (pend_disk) begin
            ack_code = CODE_DISK;
        end else if (pend_input) begin
            ack_code = CODE_INPUT;
        end else if (pend_quantum) begin
            ack_code = CODE_QUANTUM;
        end
        clr_disk  = ack && pend_disk;
        clr_input = ack && !pend_disk && pend_input;
    end

    always_comb begin
        state_next = state;
        intr_next  = intr;
        code_next  = intCode;
        pc_next    = intPc;
        case (state)
            IDLE: begin
                if (isUser && any_pending) begin
                    state_next = REQ;
                    intr_next  = 1'b1;
                end
            end
            REQ: begin
                if (inta) begin
                    state_next = SERVICE;
                    intr_next  = 1'b0;
                    code_next  = ack_code;
                    pc_next    = pc;
                end
            end
            SERVICE: begin
                if (clearIntr) begin
                    state_next = IDLE;
                    code_next  = CODE_NONE;
                end
            end
            default: begin
                state_next = IDLE;
                intr_next  = 1'b0;
            end
        endcase
    end

    // Acknowledge drops to kernel as well, and kernelMode beats userMode.
    always_comb begin
        user_next = isUser;
        if (kernelMode || ack) begin
            user_next = 1'b0;
        end else if (userMode) begin
            user_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            intr    <= 1'b0;
            intCode <= CODE_NONE;
            intPc   <= 32'd0;
            isUser  <= 1'b0;
        end else begin
            state   <= state_next;
            intr    <= intr_next;
            intCode <= code_next;
            intPc   <= pc_next;
            isUser  <= user_next;
        end
    end

    // A new event in the same cycle as its acknowledge keeps the bit set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_input <= 1'b0;
            pend_disk  <= 1'b0;
        end else begin
            pend_input <= ioReq || (pend_input && !clr_input);
            pend_disk  <= diskDone || (pend_disk && !clr_disk);
        end
    end

`ifdef INTR_TIMER_EN
    localparam logic [15:0] QUANTUM_LAST = 16'(QUANTUM - 1);

    logic [15:0] quantum_count;
    logic        count_en;
    logic        quantum_tick;
    logic        clr_quantum;

    always_comb begin
        count_en     = isUser && (state == IDLE);
        quantum_tick = count_en && !userMode && (quantum_count == QUANTUM_LAST);
        clr_quantum  = ack && !pend_disk && !pend_input && pend_quantum;
    end

    // Counts user time in IDLE only; restarts on each userMode and acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quantum_count <= 16'd0;
        end else if (userMode || ack) begin
            quantum_count <= 16'd0;
        end else if (count_en) begin
            quantum_count <= quantum_tick ? 16'd0 : quantum_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_quantum <= 1'b0;
        end else begin
            pend_quantum <= quantum_tick || (pend_quantum && !clr_quantum);
        end
    end
`else
    assign pend_quantum = 1'b0;
`endif

endmodule

// File: doc/controlador_de_interrupcao.md
CONTROLADOR_DE_INTERRUPCAO -- requirements
Module: controlador_de_interrupcao

Interface
- REQ-001 Parameter QUANTUM, default 1000: user-mode cycles between preemption (timer) requests; legal range 2..65535.
- REQ-002 clk  input  1  single system clock; all state updates on rising edge.
- REQ-003 rst  input  1  reset, asynchronous, active-low; state cleared immediately on assertion.
- REQ-004 userMode  input  1  control-unit pulse (exec / exec_again) selecting user mode.
- REQ-005 kernelMode  input  1  control-unit pulse (syscall) selecting kernel mode.
- REQ-006 inta  input  1  interrupt acknowledge from the control unit.
- REQ-007 clearIntr  input  1  control-unit pulse (cic) ending service.
- REQ-008 ioReq  input  1  one-cycle pulse: input device has data.
- REQ-009 diskDone  input  1  one-cycle pulse: disk transfer complete.
- REQ-010 pc  input  32  current program counter.
- REQ-011 intr  output  1  registered interrupt request to the control unit.
- REQ-012 intCode  output  32  held cause code (gic): 0 none, 1 quantum, 2 input, 3 disk.
- REQ-013 intPc  output  32  PC captured at acknowledge (gip).
- REQ-014 isUser  output  1  current mode flag (1 user, 0 kernel).

Function
- REQ-015 Three sticky pending bits (quantum, input, disk) SHALL be set by their source events and cleared only when that source is acknowledged or on reset.
- REQ-016 A set and a clear of the same pending bit in one cycle SHALL resolve as set.
- REQ-017 Mode flag SHALL be set by userMode, cleared by kernelMode or by acknowledge; kernelMode SHALL win if both userMode and kernelMode are high.
- REQ-018 FSM states: IDLE, REQ, SERVICE.
- REQ-019 IDLE -> REQ when isUser=1 and any pending bit is set; intr SHALL be high from the next edge (one-cycle latency).
- REQ-020 REQ: intr held high until inta is sampled high; pending events in kernel mode SHALL be held, not raised.
- REQ-021 On inta high in REQ: intCode <= highest-priority pending code (disk 3 > input 2 > quantum 1), intPc <= pc, that pending bit cleared, isUser <= 0, intr <= 0, state <= SERVICE, all on the same edge.
- REQ-022 inta while in IDLE or SERVICE SHALL be ignored.
- REQ-023 SERVICE: intCode and intPc held stable; clearIntr SHALL set intCode <= 0 and state <= IDLE; intPc SHALL retain its value.
- REQ-024 Events arriving in REQ or SERVICE SHALL be latched in pending and raised after return to IDLE in user mode.
- REQ-025 Quantum counter (16 bits) SHALL increment only while isUser=1 and state=IDLE; at QUANTUM-1 it SHALL set the quantum pending bit and wrap to 0.
- REQ-026 Quantum counter SHALL reset to 0 on every userMode pulse and on every acknowledge.
- REQ-027 clearIntr in IDLE or REQ SHALL have no effect.

Reset
- REQ-028 While rst=0: state IDLE, intr=0, intCode=0, intPc=0, isUser=0, pending bits 0, quantum counter 0.
- REQ-029 Reset asserted in REQ or SERVICE SHALL abandon the interrupt without any acknowledge side effect; source events during reset SHALL be dropped.

Configuration
- REQ-030 Macro INTR_TIMER_EN defined: quantum counter and code 1 present per REQ-025/026.
- REQ-031 INTR_TIMER_EN undefined: no counter logic, quantum pending bit constant 0, code 1 never produced; all other behaviour identical.

Verification
- REQ-032 userMode pulse, ioReq pulse -> intr=1 next cycle; inta=1 with pc=0x40 -> intCode=2, intPc=0x40, intr=0, isUser=0.
- REQ-033 ioReq and diskDone same cycle in user mode -> first acknowledge intCode=3; after clearIntr and userMode, second acknowledge intCode=2.
- REQ-034 INTR_TIMER_EN, QUANTUM=4, userMode pulse, no events -> intr rises 5 cycles after the pulse, acknowledge gives intCode=1; kernelMode before count expiry -> no intr.
- REQ-035 diskDone during SERVICE -> intr stays 0; clearIntr then userMode -> intr=1 next cycle, intCode=3 on acknowledge.
- REQ-036 rst=0 asynchronously while in REQ -> intr, intCode, isUser, pending all 0 immediately; after release no intr without new events.
- REQ-037 INTR_TIMER_EN undefined, 70000 user-mode cycles idle -> intr never asserted.
